// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SRAM / memory-mapped I/O access controller.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ACT   = 3'd1,
    RD_DONE  = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } mem_state_t;

  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
  localparam int          CNT_W           = 3;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
    logic data_oe;
    logic busy;
    logic rd_valid;
    logic wr_done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1,
                                  lb_n: 1'b1, data_oe: 1'b0, busy: 1'b0,
                                  rd_valid: 1'b0, wr_done: 1'b0};

  // Control pins for a given state; an I/O access keeps every SRAM strobe inactive.
  function automatic ctrl_t decode_ctrl(input mem_state_t s, input logic io);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      IDLE: c = CTRL_IDLE;
      RD_ACT: begin
        c.ce_n = io;
        c.oe_n = io;
        c.ub_n = io;
        c.lb_n = io;
        c.busy = 1'b1;
      end
      RD_DONE: begin
        c.busy     = 1'b1;
        c.rd_valid = 1'b1;
      end
      WR_SETUP: begin
        c.ce_n    = io;
        c.ub_n    = io;
        c.lb_n    = io;
        c.data_oe = ~io;
        c.busy    = 1'b1;
      end
      WR_PULSE: begin
        c.ce_n    = io;
        c.we_n    = io;
        c.ub_n    = io;
        c.lb_n    = io;
        c.data_oe = ~io;
        c.busy    = 1'b1;
      end
      WR_HOLD: begin
        c.ce_n    = io;
        c.ub_n    = io;
        c.lb_n    = io;
        c.data_oe = ~io;
        c.busy    = 1'b1;
        c.wr_done = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_req_detect.sv
// Rising-edge detection of the sequencer's OE/WE levels; a write edge
// masks a simultaneous read edge, and edges outside IDLE are dropped.
module mem_req_detect
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mem_oe,
  input  logic mem_we,
  input  logic idle,
  output logic rd_req,
  output logic wr_req
);

  logic oe_prev_r;
  logic we_prev_r;
  logic oe_rise_s;
  logic we_rise_s;

  // History tracks the levels every cycle so a held level never re-fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_prev_r <= 1'b0;
      we_prev_r <= 1'b0;
    end else begin
      oe_prev_r <= mem_oe;
      we_prev_r <= mem_we;
    end
  end

  // Edge qualification and write-over-read arbitration.
  always_comb begin
    oe_rise_s = mem_oe & ~oe_prev_r;
    we_rise_s = mem_we & ~we_prev_r;
    wr_req    = idle & we_rise_s;
    rd_req    = idle & oe_rise_s & ~we_rise_s;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Turns sequencer OE/WE strobes into timed SRAM read/write cycles and
// decodes a single memory-mapped I/O word (switches in, hex display out).
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          RD_WAIT = 1,
  parameter int          WR_WAIT = 1,
  parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] Wr_data,
  input  logic [15:0] Switches,
  input  logic [15:0] Data_from_SRAM,
  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        Data_oe,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic [15:0] Rd_data,
  output logic        Rd_valid,
  output logic        Wr_done,
  output logic [15:0] Hex_out,
  output logic        Busy
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mem_state_t       state_r;
  mem_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             is_io_r;
  logic             is_io_nxt_s;
  ctrl_t            ctrl_r;
  ctrl_t            ctrl_nxt_s;
  logic             rd_req_s;
  logic             wr_req_s;
  logic [15:0]      mar_r;
  logic [15:0]      wdata_r;
  logic [15:0]      rd_data_r;
  logic [15:0]      hex_r;

  mem_req_detect u_req_detect (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .mem_oe (Mem_OE),
    .mem_we (Mem_WE),
    .idle   (state_r == IDLE),
    .rd_req (rd_req_s),
    .wr_req (wr_req_s)
  );

  // Next-state and wait-counter logic; the counter is loaded with WAIT-1 on entry.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    is_io_nxt_s = is_io_r;
    case (state_r)
      IDLE: begin
        if (wr_req_s) begin
          state_nxt_s = WR_SETUP;
          cnt_nxt_s   = '0;
          is_io_nxt_s = (MAR == IO_ADDR);
        end else if (rd_req_s) begin
          state_nxt_s = RD_ACT;
          cnt_nxt_s   = RD_LOAD;
          is_io_nxt_s = (MAR == IO_ADDR);
        end else begin
          cnt_nxt_s = '0;
        end
      end
      RD_ACT: begin
        if (cnt_r == '0) begin
          state_nxt_s = RD_DONE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      RD_DONE: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
      WR_SETUP: begin
        state_nxt_s = WR_PULSE;
        cnt_nxt_s   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt_r == '0) begin
          state_nxt_s = WR_HOLD;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      WR_HOLD: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
    ctrl_nxt_s = decode_ctrl(state_nxt_s, is_io_nxt_s);
  end

  // FSM registers; control pins are registered alongside the state they belong to.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      is_io_r <= 1'b0;
      ctrl_r  <= CTRL_IDLE;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      is_io_r <= is_io_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
    end
  end

  // Address/data latches, read capture and the I/O display register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mar_r     <= 16'h0000;
      wdata_r   <= 16'h0000;
      rd_data_r <= 16'h0000;
      hex_r     <= 16'h0000;
    end else begin
      if (rd_req_s || wr_req_s) begin
        mar_r   <= MAR;
        wdata_r <= Wr_data;
      end
      if (state_r == RD_ACT && cnt_r == '0) begin
        rd_data_r <= is_io_r ? Switches : Data_from_SRAM;
      end
      if (state_r == WR_PULSE && cnt_r == '0 && is_io_r) begin
        hex_r <= wdata_r;
      end
    end
  end

  assign ADDR         = {4'h0, mar_r};
  assign Data_to_SRAM = wdata_r;
  assign Data_oe      = ctrl_r.data_oe;
  assign SRAM_CE_N    = ctrl_r.ce_n;
  assign SRAM_OE_N    = ctrl_r.oe_n;
  assign SRAM_WE_N    = ctrl_r.we_n;
  assign SRAM_UB_N    = ctrl_r.ub_n;
  assign SRAM_LB_N    = ctrl_r.lb_n;
  assign Rd_data      = rd_data_r;
  assign Rd_valid     = ctrl_r.rd_valid;
  assign Wr_done      = ctrl_r.wr_done;
  assign Hex_out      = hex_r;
  assign Busy         = ctrl_r.busy;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: two controller builds (1/1 and 3/2 wait states) share one
// stimulus stream and are checked cycle by cycle against an access-timeline model.
module tb_mem_access_ctrl;

  localparam int RD0 = 1;
  localparam int WR0 = 1;
  localparam int RD1 = 3;
  localparam int WR1 = 2;
  localparam logic [8:0] IDLE_V = 9'b11111_0000;

  typedef struct {
    bit          wr;
    bit          io;
    int          acc;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } rec_t;

  logic        Clk;
  logic        Reset_n;
  logic        Mem_OE, Mem_WE;
  logic [15:0] MAR, Wr_data, Switches;

  logic [19:0] addr_o [2];
  logic [15:0] dts_o [2];
  logic [15:0] dfs [2];
  logic [15:0] rd_o [2];
  logic [15:0] hex_o [2];
  logic        doe_o [2], ce_o [2], oe_o [2], we_o [2], ub_o [2], lb_o [2];
  logic        rv_o [2], wd_o [2], busy_o [2];

  logic [15:0] sram [2][16];
  logic [15:0] ref_mem [2][16];
  logic [15:0] exp_rd [2];
  logic [15:0] exp_hex [2];
  int          busy_until [2];
  bit          prev_oe, prev_we;
  rec_t        q0[$];
  rec_t        q1[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  mem_access_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .MAR(MAR),
    .Wr_data(Wr_data), .Switches(Switches), .Data_from_SRAM(dfs[0]), .ADDR(addr_o[0]),
    .Data_to_SRAM(dts_o[0]), .Data_oe(doe_o[0]), .SRAM_CE_N(ce_o[0]), .SRAM_OE_N(oe_o[0]),
    .SRAM_WE_N(we_o[0]), .SRAM_UB_N(ub_o[0]), .SRAM_LB_N(lb_o[0]), .Rd_data(rd_o[0]),
    .Rd_valid(rv_o[0]), .Wr_done(wd_o[0]), .Hex_out(hex_o[0]), .Busy(busy_o[0])
  );

  mem_access_ctrl #(.RD_WAIT(RD1), .WR_WAIT(WR1)) dut_slow (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .MAR(MAR),
    .Wr_data(Wr_data), .Switches(Switches), .Data_from_SRAM(dfs[1]), .ADDR(addr_o[1]),
    .Data_to_SRAM(dts_o[1]), .Data_oe(doe_o[1]), .SRAM_CE_N(ce_o[1]), .SRAM_OE_N(oe_o[1]),
    .SRAM_WE_N(we_o[1]), .SRAM_UB_N(ub_o[1]), .SRAM_LB_N(lb_o[1]), .Rd_data(rd_o[1]),
    .Rd_valid(rv_o[1]), .Wr_done(wd_o[1]), .Hex_out(hex_o[1]), .Busy(busy_o[1])
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input logic [3:0] i);
    return {12'h100, i};
  endfunction

  // Behavioural SRAM: written on any clock edge where CE_N and WE_N are both low.
  always @(posedge Clk) begin
    if (cyc == 0) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 16; i++) sram[d][i] <= init_word(4'(i));
    end else begin
      for (int d = 0; d < 2; d++)
        if (!ce_o[d] && !we_o[d]) sram[d][addr_o[d][3:0]] <= dts_o[d];
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++)
      dfs[d] = (!ce_o[d] && !oe_o[d]) ? sram[d][addr_o[d][3:0]] : 16'hDEAD;
  end

  task automatic chk(input bit ok, input string name, input int d,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d actual=%h expected=%h", name, d, cyc, act, exp);
    end
  endtask

  // Expected {CE,OE,WE,UB,LB,Data_oe,Busy,Rd_valid,Wr_done} at offset o after acceptance.
  function automatic logic [8:0] exp_ctrl(input bit wr, input bit io, input int o,
                                          input int rdw, input int wrw);
    logic s;
    s = io;
    if (!wr) begin
      if (o < rdw) return {s, s, 1'b1, s, s, 1'b0, 1'b1, 1'b0, 1'b0};
      return {5'b11111, 1'b0, 1'b1, 1'b1, 1'b0};
    end
    if (o == 0)   return {s, 1'b1, 1'b1, s, s, ~s, 1'b1, 1'b0, 1'b0};
    if (o <= wrw) return {s, 1'b1, s, s, s, ~s, 1'b1, 1'b0, 1'b0};
    return {s, 1'b1, 1'b1, s, s, ~s, 1'b1, 1'b0, 1'b1};
  endfunction

  task automatic check_dut(input int d);
    rec_t r;
    bit have;
    int o, rdw, wrw, last;
    logic [8:0] e, a;
    rdw  = (d == 0) ? RD0 : RD1;
    wrw  = (d == 0) ? WR0 : WR1;
    have = 1'b0;
    o    = -1;
    if (d == 0 && q0.size() > 0) begin have = 1'b1; r = q0[0]; end
    else if (d == 1 && q1.size() > 0) begin have = 1'b1; r = q1[0]; end
    if (have) o = cyc - r.acc;
    e = have ? exp_ctrl(r.wr, r.io, o, rdw, wrw) : IDLE_V;
    a = {ce_o[d], oe_o[d], we_o[d], ub_o[d], lb_o[d], doe_o[d], busy_o[d], rv_o[d], wd_o[d]};
    chk(a == e, "ctrl", d, 64'(a), 64'(e));
    if (have) begin
      if (r.wr) chk({addr_o[d], dts_o[d]} == {4'h0, r.addr, r.wdata}, "addr_wdata", d,
                    64'({addr_o[d], dts_o[d]}), 64'({4'h0, r.addr, r.wdata}));
      else chk(addr_o[d] == {4'h0, r.addr}, "addr", d, 64'(addr_o[d]), 64'({4'h0, r.addr}));
      last = r.wr ? wrw + 1 : rdw;
      if (o >= last) begin
        if (!r.wr) exp_rd[d] = r.rdata;
        else if (r.io) exp_hex[d] = r.wdata;
        if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end else if (!Reset_n) begin
      chk({addr_o[d], dts_o[d]} == 36'h0, "rst_addr", d, 64'({addr_o[d], dts_o[d]}), 64'h0);
    end
    if (!Reset_n) begin
      exp_rd[d]  = 16'h0000;
      exp_hex[d] = 16'h0000;
    end
    chk({rd_o[d], hex_o[d]} == {exp_rd[d], exp_hex[d]}, "rd_hex", d,
        64'({rd_o[d], hex_o[d]}), 64'({exp_rd[d], exp_hex[d]}));
  endtask

  // Monitor: compares both builds against the scoreboard on every falling edge.
  always @(negedge Clk) begin
    for (int d = 0; d < 2; d++) check_dut(d);
  end

  // One stimulus cycle; the reference decides acceptance from edges and busy windows.
  task automatic drive(input bit oe, input bit we, input logic [15:0] mar,
                       input logic [15:0] wd, input logic [15:0] sw);
    int p;
    bit eo, ew;
    rec_t r;
    @(negedge Clk);
    #1;
    p       = cyc + 1;
    Mem_OE  = oe;
    Mem_WE  = we;
    MAR     = mar;
    Wr_data = wd;
    if (p > busy_until[0] && p > busy_until[1]) Switches = sw;
    eo = oe && !prev_oe;
    ew = we && !prev_we;
    for (int d = 0; d < 2; d++) begin
      if (Reset_n && (eo || ew) && p > busy_until[d]) begin
        r.wr    = ew;
        r.io    = (mar == 16'hFFFF);
        r.acc   = p;
        r.addr  = mar;
        r.wdata = wd;
        r.rdata = 16'h0000;
        if (ew) begin
          if (!r.io) ref_mem[d][mar[3:0]] = wd;
          busy_until[d] = p + ((d == 0) ? WR0 : WR1) + 2;
        end else begin
          r.rdata = r.io ? Switches : ref_mem[d][mar[3:0]];
          busy_until[d] = p + ((d == 0) ? RD0 : RD1) + 1;
        end
        if (d == 0) q0.push_back(r); else q1.push_back(r);
      end
    end
    prev_oe = Reset_n ? oe : 1'b0;
    prev_we = Reset_n ? we : 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, MAR, Wr_data, Switches);
  endtask

  task automatic req(input bit oe, input bit we, input logic [15:0] mar,
                     input logic [15:0] wd, input logic [15:0] sw, input int hold);
    repeat (hold) drive(oe, we, mar, wd, sw);
    idle(6);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) ref_mem[d][i] = init_word(4'(i));
      busy_until[d] = 0;
      exp_rd[d]     = 16'h0000;
      exp_hex[d]    = 16'h0000;
    end
    prev_oe  = 1'b0;
    prev_we  = 1'b0;
    Mem_OE   = 1'b0;
    Mem_WE   = 1'b0;
    MAR      = 16'h0000;
    Wr_data  = 16'h0000;
    Switches = 16'h0000;
    Reset_n  = 1'b1;
    #2 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    #1 Reset_n = 1'b1;
    idle(2);

    // I/O write aborted by reset while in the write pulse.
    drive(1'b0, 1'b1, 16'hFFFF, 16'h00A5, Switches);
    drive(1'b0, 1'b1, 16'hFFFF, 16'h00A5, Switches);
    @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    Mem_WE  = 1'b0;
    q0.delete();
    q1.delete();
    busy_until[0] = 0;
    busy_until[1] = 0;
    prev_oe = 1'b0;
    prev_we = 1'b0;
    #1;
    chk({hex_o[0], hex_o[1], we_o[0], we_o[1], busy_o[0], busy_o[1]} == {32'h0, 2'b11, 2'b00},
        "async_rst", -1, 64'({hex_o[0], hex_o[1], we_o[0], we_o[1], busy_o[0], busy_o[1]}),
        64'({32'h0, 2'b11, 2'b00}));
    repeat (2) @(negedge Clk);
    #1 Reset_n = 1'b1;
    idle(2);

    req(1'b0, 1'b1, 16'h0042, 16'h1234, Switches, 3);
    req(1'b1, 1'b0, 16'h0042, 16'h0000, Switches, 3);
    req(1'b0, 1'b1, 16'h0010, 16'hBEEF, Switches, 3);
    req(1'b1, 1'b0, 16'h0010, 16'h0000, Switches, 3);
    req(1'b0, 1'b1, 16'hFFFF, 16'h00A5, Switches, 3);
    req(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 3);
    req(1'b1, 1'b1, 16'h0003, 16'h1111, Switches, 3);
    req(1'b1, 1'b0, 16'h0003, 16'h0000, Switches, 3);
    req(1'b1, 1'b0, 16'h0007, 16'h0000, Switches, 10);

    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 2) == 0) ? ~Mem_OE : Mem_OE,
            ($urandom_range(0, 3) == 0) ? ~Mem_WE : Mem_WE,
            ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 15)),
            16'($urandom), 16'($urandom));
    end
    idle(10);
    chk(q0.size() == 0 && q1.size() == 0, "drain", -1, 64'(q0.size() + q1.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side neighbour of the instruction sequencer/decoder. It consumes the sequencer's level-style Mem_OE/Mem_WE strobes and MAR/MDR values.
- It turns each strobe into a timed SRAM read or write cycle and returns read data for the MDR load.
- It decodes one memory-mapped I/O word: reads return the switches, writes go to a hex-display register.

Parameters:
- RD_WAIT, 1: cycles SRAM_OE_N is held low before read data is sampled (1..4).
- WR_WAIT, 1: cycles SRAM_WE_N is held low (1..4).
- IO_ADDR, 16'hFFFF: MAR value that selects I/O instead of SRAM.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Mem_OE  in  1  read request level from sequencer.
- Mem_WE  in  1  write request level from sequencer.
- MAR  in  16  word address.
- Wr_data  in  16  write data (MDR).
- Switches  in  16  I/O read source.
- Data_from_SRAM  in  16  SRAM read bus.
- ADDR  out  20  SRAM address = {4'b0, latched MAR}.
- Data_to_SRAM  out  16  latched write data.
- Data_oe  out  1  drive enable for the external tristate.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  SRAM controls, active-low.
- Rd_data  out  16  captured read word, held until the next read completes.
- Rd_valid  out  1  one-cycle pulse when Rd_data is updated.
- Wr_done  out  1  one-cycle pulse at write completion.
- Hex_out  out  16  I/O write register.
- Busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State=IDLE.
  - All *_N outputs = 1, Data_oe=0, Rd_valid=0, Wr_done=0, Busy=0.
  - Rd_data=0, Hex_out=0, ADDR=0, Data_to_SRAM=0.
  - Edge-detect history = 0.
  - Reset mid-cycle aborts the access; no partial Hex_out update.
- Request detection:
  - A request is a rising edge of Mem_OE or Mem_WE (current=1, registered previous=0), sampled only in IDLE.
  - A held level never retriggers. Edges arriving while Busy are dropped.
  - Simultaneous OE and WE edges: the write wins and the read is discarded.
  - On acceptance (edge at the end of request cycle n): latch MAR and Wr_data, and set is_io = (MAR == IO_ADDR).
- Once accepted, an access always runs to completion. Deasserting Mem_OE/Mem_WE does not abort it.
- States: IDLE, RD_ACT, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD. All outputs are Moore, decoded from registered state and counter.
- Read path:
  - IDLE -> RD_ACT for RD_WAIT cycles. SRAM CE_N=OE_N=UB_N=LB_N=0, unless is_io, in which case all stay 1.
  - Rd_data is captured on the final RD_ACT edge: Data_from_SRAM, or Switches when is_io.
  - -> RD_DONE for 1 cycle: Rd_valid=1, all *_N=1.
  - -> IDLE.
  - Default timing: request cycle n, RD_ACT n+1, Rd_valid n+2. This fits inside the sequencer's three-cycle OE window.
- Write path:
  - IDLE -> WR_SETUP for 1 cycle: CE_N=UB_N=LB_N=0, WE_N=1, Data_oe=1.
  - -> WR_PULSE for WR_WAIT cycles: WE_N=0, Data_oe=1.
  - -> WR_HOLD for 1 cycle: WE_N=1, CE_N=0, Data_oe=1, Wr_done=1.
  - -> IDLE.
  - If is_io: every SRAM *_N stays 1 and Data_oe=0. Hex_out is loaded on the WR_PULSE->WR_HOLD edge. Latency is identical to an SRAM write.
- Wait counter: 3 bits, loaded with WAIT-1 on state entry, decremented each cycle. The state exits when the counter is 0.
- Invariants:
  - SRAM_OE_N and SRAM_WE_N are never both 0.
  - Data_oe=1 only in write states.
  - ADDR and Data_to_SRAM are stable from WR_SETUP through WR_HOLD.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the state enum mem_state_t (6 states, 3-bit encoding);
  - the IO_ADDR default;
  - the wait-counter width constant.
- One sub-module, mem_req_detect: two-bit edge detector plus write-priority arbitration, gated by IDLE. It outputs rd_req and wr_req pulses.

Test Plan:
- Read SRAM: MAR=16'h0042, Data_from_SRAM=16'h1234, Mem_OE high for 3 cycles from cycle n -> OE_N/CE_N low in cycle n+1, Rd_data=16'h1234 with Rd_valid=1 in n+2, ADDR=20'h00042.
- Write SRAM: MAR=16'h0010, Wr_data=16'hBEEF, Mem_WE high for 3 cycles -> WE_N low only in n+2, Data_oe=1 for n+1..n+3, Wr_done in n+3, Data_to_SRAM=16'hBEEF throughout.
- I/O: write 16'h00A5 to MAR=16'hFFFF -> Hex_out=16'h00A5 at n+3 with all *_N=1. Then read FFFF with Switches=16'h0F0F -> Rd_data=16'h0F0F, SRAM never enabled.
- Simultaneous Mem_OE/Mem_WE edges -> write sequence only, no Rd_valid. Holding Mem_OE high for 10 cycles -> exactly one Rd_valid.
- Reset_n pulled low during WR_PULSE -> outputs immediately go to reset values, Hex_out unchanged from 0. A request after release completes normally.
- RD_WAIT=3, WR_WAIT=2 build -> Rd_valid at n+4, WE_N low in n+2..n+3, Wr_done at n+4.
